// File: rtl/frame_capture_pkg.sv
// Shared types and default geometry for the frame capture buffer.
package frame_capture_pkg;
  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  localparam int DEF_ARRAY_WIDTH   = 10;
  localparam int DEF_ARRAY_HEIGHT  = 10;
  localparam int DEF_COUNTER_WIDTH = 8;
endpackage

// File: rtl/frame_mem.sv
// Simple dual-port frame store: synchronous write, registered read with enable, no reset.
module frame_mem #(
  parameter int DEPTH = 100,
  parameter int DW    = 8,
  parameter int AW    = 7
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    // Read data holds while re_i is low so a stalled fetch stays valid.
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/frame_capture.sv
// Captures one frame of pixel strobes, then drains it in raster order over a valid/ready port.
// Optional FRAME_CAPTURE_STATS_EN adds per-frame min/max and a completed-frame counter.
module frame_capture
  import frame_capture_pkg::*;
#(
  parameter int array_width   = DEF_ARRAY_WIDTH,
  parameter int array_height  = DEF_ARRAY_HEIGHT,
  parameter int counter_width = DEF_COUNTER_WIDTH
) (
  input  logic                     system_clk,
  input  logic                     reset,
  input  logic                     read,
  input  logic [counter_width-1:0] pixel_out,
  output logic [counter_width-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sof,
  output logic                     out_eof,
  output logic                     frame_done,
  output logic                     overrun,
  output logic                     busy
`ifdef FRAME_CAPTURE_STATS_EN
  ,
  output logic [counter_width-1:0] frame_min,
  output logic [counter_width-1:0] frame_max,
  output logic [15:0]              frame_count
`endif
);
  localparam int N  = array_width * array_height;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t                   state_q;
  logic [IW-1:0]            wr_idx_q, wr_idx_d, rd_idx_q, f_idx_q;
  logic                     rd_done_q, f_vld_q;
  logic                     out_valid_q, out_sof_q, out_eof_q, overrun_q;
  logic [counter_width-1:0] out_data_q, rdata;
  logic                     eof_acc, wr_en, load_out, issue;

  // The eof-accept cycle already counts as FILL for an incoming strobe.
  assign eof_acc  = out_valid_q & out_ready & out_eof_q;
  assign wr_en    = read & ((state_q == FILL) | eof_acc);
  assign load_out = f_vld_q & (~out_valid_q | out_ready);
  assign issue    = (state_q == DRAIN) & ~rd_done_q & (~f_vld_q | load_out);
  assign wr_idx_d = (wr_idx_q == LAST) ? '0 : wr_idx_q + 1'b1;

  frame_mem #(.DEPTH(N), .DW(counter_width), .AW(IW)) u_mem (
    .clk_i   (system_clk),
    .we_i    (wr_en),
    .waddr_i (wr_idx_q),
    .wdata_i (pixel_out),
    .re_i    (issue),
    .raddr_i (rd_idx_q),
    .rdata_o (rdata)
  );

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      rd_done_q   <= 1'b0;
      f_vld_q     <= 1'b0;
      f_idx_q     <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_data_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      if (wr_en) wr_idx_q <= wr_idx_d;
      if (state_q == FILL) begin
        if (wr_en && wr_idx_q == LAST) state_q <= DRAIN;
      end else begin
        if (read && !eof_acc) overrun_q <= 1'b1;
        if (eof_acc) state_q <= FILL;
      end

      if (issue) begin
        rd_idx_q  <= rd_idx_q + 1'b1;
        rd_done_q <= (rd_idx_q == LAST);
      end else if (eof_acc) begin
        rd_idx_q  <= '0;
        rd_done_q <= 1'b0;
      end

      if (issue) begin
        f_vld_q <= 1'b1;
        f_idx_q <= rd_idx_q;
      end else if (load_out) begin
        f_vld_q <= 1'b0;
      end

      if (load_out) begin
        out_valid_q <= 1'b1;
        out_data_q  <= rdata;
        out_sof_q   <= (f_idx_q == '0);
        out_eof_q   <= (f_idx_q == LAST);
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
        out_sof_q   <= 1'b0;
        out_eof_q   <= 1'b0;
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_sof    = out_sof_q;
  assign out_eof    = out_eof_q;
  assign frame_done = eof_acc;
  assign overrun    = overrun_q;
  assign busy       = (state_q == DRAIN);

`ifdef FRAME_CAPTURE_STATS_EN
  logic [counter_width-1:0] run_min_q, run_max_q, frame_min_q, frame_max_q, nmin, nmax;
  logic [15:0]              frame_count_q;

  // Pixel 0 of a frame restarts the running extremes.
  assign nmin = (wr_idx_q == '0 || pixel_out < run_min_q) ? pixel_out : run_min_q;
  assign nmax = (wr_idx_q == '0 || pixel_out > run_max_q) ? pixel_out : run_max_q;

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      run_min_q     <= '1;
      run_max_q     <= '0;
      frame_min_q   <= '1;
      frame_max_q   <= '0;
      frame_count_q <= '0;
    end else begin
      if (wr_en) begin
        run_min_q <= nmin;
        run_max_q <= nmax;
        if (wr_idx_q == LAST) begin
          frame_min_q <= nmin;
          frame_max_q <= nmax;
        end
      end
      if (eof_acc) frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign frame_min   = frame_min_q;
  assign frame_max   = frame_max_q;
  assign frame_count = frame_count_q;
`endif
endmodule

// File: tb/tb_frame_capture.sv
// Self-checking bench for frame_capture: directed scenarios with random pixel data and a queue-based frame model.
module tb_frame_capture;
  localparam int W = 10, H = 10, CW = 8, N = W * H;

  logic          clk = 1'b0, rst = 1'b1, read = 1'b0, ready = 1'b1;
  logic [CW-1:0] pix = '0;
  logic [CW-1:0] out_data;
  logic          out_valid, out_sof, out_eof, frame_done, overrun, busy;
`ifdef FRAME_CAPTURE_STATS_EN
  logic [CW-1:0] fmin, fmax;
  logic [15:0]   fcnt;
`endif

  always #5 clk = ~clk;

  frame_capture #(.array_width(W), .array_height(H), .counter_width(CW)) dut (
    .system_clk (clk),
    .reset      (rst),
    .read       (read),
    .pixel_out  (pix),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (ready),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .frame_done (frame_done),
    .overrun    (overrun),
    .busy       (busy)
`ifdef FRAME_CAPTURE_STATS_EN
    ,
    .frame_min  (fmin),
    .frame_max  (fmax),
    .frame_count(fcnt)
`endif
  );

  int total = 0, bad = 0, done_cnt = 0;
  typedef struct {logic [CW-1:0] d; logic s; logic e;} beat_t;
  beat_t         got_q[$];
  logic [CW-1:0] exp_q[$];
  logic          pv = 1'b0, pr = 1'b0, ps = 1'b0, pe = 1'b0;
  logic [CW-1:0] pd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Passive monitor: collects accepted beats and checks hold/stall rules every cycle.
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      chk("valid_in_fill", 32'(out_valid & ~busy), 32'd0);
      chk("done_vs_eof_accept", 32'(frame_done), 32'(out_valid & ready & out_eof));
      if (pv && !pr)
        chk("stall_hold", 32'({out_valid, out_data, out_sof, out_eof}), 32'({1'b1, pd, ps, pe}));
      if (out_valid && ready) got_q.push_back('{out_data, out_sof, out_eof});
      if (frame_done) done_cnt++;
      pv = out_valid; pr = ready; pd = out_data; ps = out_sof; pe = out_eof;
    end
  end

  task automatic strobe(input logic [CW-1:0] v);
    read = 1'b1; pix = v;
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  // mode 0: base+i, mode 1: random; every captured value goes into the model frame.
  task automatic fill(input int mode, input int base, input int cnt);
    logic [CW-1:0] v;
    for (int i = 0; i < cnt; i++) begin
      v = (mode == 0) ? CW'(base + i) : CW'($urandom_range(0, 255));
      strobe(v);
      exp_q.push_back(v);
    end
  endtask

  // mode 0: ready high, 1: toggle each cycle, 2: random ready.
  task automatic wait_done(input int mode, input string tag, output int cyc);
    int base;
    bit ok;
    base = done_cnt; ok = 1'b0; cyc = 0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      cyc = c + 1;
      if (done_cnt != base) begin ok = 1'b1; break; end
      if (mode == 1) ready = ~ready;
      else if (mode == 2) ready = 1'($urandom_range(0, 1));
    end
    ready = 1'b1;
    chk({tag, "_done_seen"}, 32'(ok), 32'd1);
    chk({tag, "_one_done"}, 32'(done_cnt - base), 32'd1);
  endtask

  task automatic check_frame(input string tag);
    int errs;
    errs = 0;
    chk({tag, "_len"}, 32'(got_q.size()), 32'(N));
    if (got_q.size() > 0) chk({tag, "_first_px"}, 32'(got_q[0].d), 32'(exp_q[0]));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i].d !== exp_q[i] || got_q[i].s !== (i == 0) || got_q[i].e !== (i == N - 1))
        errs++;
    chk({tag, "_px_errs"}, 32'(errs), 32'd0);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int cyc, base;
    bit seen;
    logic [CW-1:0] x;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_flags", 32'({out_valid, out_sof, out_eof, frame_done, overrun, busy}), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // S1: 0..99, ready high, latency and throughput
    fill(0, 0, N);
    @(negedge clk);
    chk("s1_busy", 32'(busy), 32'd1);
    chk("s1_lat0", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("s1_lat1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("s1_lat2", 32'({out_valid, out_sof, out_data}), 32'({1'b1, 1'b1, 8'd0}));
    wait_done(0, "s1", cyc);
    chk("s1_rate", 32'(cyc), 32'(N));
    check_frame("s1");
    chk("s1_overrun", 32'(overrun), 32'd0);
    chk("s1_back_fill", 32'({busy, out_valid}), 32'd0);

    // S2: random frame, ready toggling
    fill(1, 0, N);
    wait_done(1, "s2", cyc);
    check_frame("s2");

    // S3: strobes during DRAIN are dropped and flag overrun
    fill(1, 0, N);
    for (int i = 0; i < 5; i++) strobe(CW'($urandom_range(0, 255)));
    chk("s3_overrun", 32'(overrun), 32'd1);
    wait_done(2, "s3", cyc);
    check_frame("s3");
    fill(1, 0, N);
    wait_done(0, "s3b", cyc);
    check_frame("s3b");
    chk("s3_overrun_sticky", 32'(overrun), 32'd1);

    // S4: async reset mid-frame discards partial data
    for (int i = 0; i < 50; i++) strobe(CW'($urandom_range(0, 255)));
    @(posedge clk); #3 rst = 1'b1;
    #1 chk("s4_async_rst", 32'({overrun, busy, out_valid}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    fill(1, 0, N);
    wait_done(0, "s4", cyc);
    check_frame("s4");

    // S5: strobe in the eof-accept cycle becomes pixel 0 of the next frame
    fill(1, 0, N);
    base = done_cnt; seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if (out_valid && out_eof) begin seen = 1'b1; break; end
    end
    chk("s5_eof_seen", 32'(seen), 32'd1);
    x = CW'($urandom_range(0, 255));
    read = 1'b1; pix = x;
    @(posedge clk); #1 read = 1'b0;
    chk("s5_done", 32'(done_cnt - base), 32'd1);
    check_frame("s5a");
    exp_q.push_back(x);
    fill(1, 0, N - 1);
    wait_done(0, "s5b", cyc);
    check_frame("s5b");

`ifdef FRAME_CAPTURE_STATS_EN
    // S6: statistics over 7..106
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("s6_rst_min", 32'(fmin), 32'hFF);
    chk("s6_rst_max_cnt", 32'({fmax, fcnt}), 32'd0);
    fill(0, 7, N);
    chk("s6_min", 32'(fmin), 32'd7);
    chk("s6_max", 32'(fmax), 32'd106);
    wait_done(0, "s6", cyc);
    chk("s6_count", 32'(fcnt), 32'd1);
    check_frame("s6");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frame_capture.md
FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 Parameter array_width, default 10: pixels per row.
REQ-002 Parameter array_height, default 10: rows per frame.
REQ-003 Parameter counter_width, default 8: bits per pixel sample.
REQ-004 system_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 read  input  1  pixel strobe from the pixel array; pixel_out is valid this cycle.
REQ-007 pixel_out  input  counter_width  digitised pixel sample.
REQ-008 out_data  output  counter_width  buffered pixel, raster order.
REQ-009 out_valid  output  1  out_data is valid.
REQ-010 out_ready  input  1  downstream accepts the pixel when out_valid && out_ready.
REQ-011 out_sof / out_eof  output  1 each  marks the first / last pixel of a frame on the out_* beat.
REQ-012 frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted.
REQ-013 overrun  output  1  sticky; a pixel strobe was dropped.
REQ-014 busy  output  1  high while in DRAIN.

Function
REQ-015 Frame size N = array_width*array_height; write and read indices are $clog2(N) bits wide.
REQ-016 FSM states: FILL and DRAIN; reset state is FILL.
REQ-017 FILL: each read strobe writes pixel_out to buffer[wr_idx], then increments wr_idx.
REQ-018 FILL: the write at wr_idx = N-1 resets wr_idx to 0 and moves the FSM to DRAIN on the next cycle.
REQ-019 DRAIN: buffer[0..N-1] is presented in order; the buffer read has 1-cycle latency, so the first out_valid is asserted 2 cycles after entering DRAIN.
REQ-020 While out_valid && !out_ready, out_data, out_sof and out_eof shall hold stable, and out_valid shall stay high.
REQ-021 With out_ready held high, DRAIN sustains one pixel per cycle after the first.
REQ-022 out_sof is high only with index 0; out_eof is high only with index N-1.
REQ-023 Acceptance of index N-1 pulses frame_done in the same cycle, drops out_valid the next cycle and returns the FSM to FILL.
REQ-024 A read strobe during DRAIN is discarded, sets overrun, and does not touch the buffer or wr_idx.
REQ-025 A read strobe in the transition cycle from DRAIN to FILL is captured as pixel 0 of the next frame.
REQ-026 out_valid shall never be high in FILL.

Reset
REQ-027 Reset clears FSM→FILL, wr_idx→0, rd_idx→0, and the outputs out_valid, out_sof, out_eof, frame_done, overrun and busy→0; out_data→0.
REQ-028 Reset mid-frame discards the partial frame; buffer contents need not be cleared.
REQ-029 overrun is cleared only by reset.

Configuration
REQ-030 Macro FRAME_CAPTURE_STATS_EN adds outputs frame_min and frame_max (counter_width each) and frame_count (16 bits).
REQ-031 With the macro defined, min/max are tracked over FILL writes and latched on the transition to DRAIN.
REQ-032 With the macro defined, frame_count increments on each frame_done and wraps at 16 bits.
REQ-033 With the macro defined, reset clears frame_min to all-ones and clears frame_max and frame_count to 0.
REQ-034 Without the macro, these ports and their logic are absent, and the remaining behaviour is identical.

Structure
REQ-035 Package frame_capture_pkg holds the FSM state enum (FILL, DRAIN) and the default parameter constants.
REQ-036 Storage is sub-module frame_mem: simple dual-port RAM, N x counter_width, synchronous write, 1-cycle registered read, no reset.

Verification
REQ-037 Scenario 1: 100 strobes with values 0..99, out_ready=1 -> out_data 0..99 in order; sof on 0, eof on 99, one frame_done pulse, overrun=0.
REQ-038 Scenario 2: full frame, then out_ready toggled every other cycle -> no duplicated or lost pixels; outputs stable while stalled.
REQ-039 Scenario 3: 5 strobes during DRAIN -> overrun=1 and latched; output frame unchanged; next FILL starts at wr_idx 0.
REQ-040 Scenario 4: reset asserted after 50 strobes, then 100 new strobes -> the output frame contains only the new values.
REQ-041 Scenario 5: strobe coincident with acceptance of the eof beat -> that value appears as sof of the next frame.
REQ-042 Scenario 6 (STATS_EN): frame values 7..106 -> frame_min=7, frame_max=106; frame_count=1 after frame_done.
